// File: rtl/clk_gate_pkg.sv
// -----------------------------------------------------------------------------
// clk_gate_pkg
// Shared types and constants for the clk_d clock-gate enable controller.
//   state_t           : controller states OFF / WAKE / ON
//   SETTLE_W, IDLE_W  : widths of the settle and idle-run counters
//   *_MIN / *_MAX     : legal parameter ranges, checked at elaboration
// -----------------------------------------------------------------------------
package clk_gate_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    WAKE = 2'd1,
    ON   = 2'd2
  } state_t;

  localparam int SETTLE_W = 4;
  localparam int IDLE_W   = 8;

  // Upper bounds are tied to the counter widths so neither counter can wrap.
  localparam int WAKE_MIN  = 1;
  localparam int WAKE_MAX  = (1 << SETTLE_W) - 1;
  localparam int IDLE_MIN  = 1;
  localparam int IDLE_MAX  = (1 << IDLE_W) - 1;
  localparam int CNT_W_MIN = 1;

endpackage

// File: rtl/clk_gate_idle_timer.sv
// -----------------------------------------------------------------------------
// clk_gate_idle_timer
// Counts consecutive idle cycles while the gated clock is ON.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : restart the idle run at zero (has priority over inc)
//   inc        : one more idle sample seen
//   tc         : idle run has reached LIMIT-1; the next idle sample ends ON
// -----------------------------------------------------------------------------
module clk_gate_idle_timer
  import clk_gate_pkg::*;
#(
  parameter int LIMIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  logic [IDLE_W-1:0] idle_run_q;
  logic [IDLE_W-1:0] idle_run_d;

  always_comb begin
    idle_run_d = idle_run_q;
    if (clr) begin
      idle_run_d = '0;
    end else if (inc) begin
      idle_run_d = idle_run_q + IDLE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idle_run_q <= '0;
    end else begin
      idle_run_q <= idle_run_d;
    end
  end

  assign tc = (idle_run_q == IDLE_W'(LIMIT - 1));

endmodule

// File: rtl/clk_gate_ctrl.sv
// -----------------------------------------------------------------------------
// clk_gate_ctrl
// Enable-side controller for a clk_d clock-gate cell. Wakes the gate on
// request, waits a settling interval before acknowledging, and shuts the gate
// after IDLE_CYCLES consecutive idle samples.
// Ports:
//   clk, rst_n : free-running always-on clock, synchronous active-low reset
//   req        : wake request from the gated-domain client
//   busy       : downstream work in flight; keeps the clock on, never wakes it
//   force_on   : debug override, behaves as req and busy together
//   en         : registered enable to the gate cell
//   ack        : registered; gated clock is stable
//   idle       : registered; high only in OFF
//   wake_cnt   : saturating count of OFF->WAKE transitions
// -----------------------------------------------------------------------------
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int WAKE_CYCLES = 2,
  parameter int IDLE_CYCLES = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic             busy,
  input  logic             force_on,
  output logic             en,
  output logic             ack,
  output logic             idle,
  output logic [CNT_W-1:0] wake_cnt
);

  if (WAKE_CYCLES < WAKE_MIN || WAKE_CYCLES > WAKE_MAX) begin : g_bad_wake
    $fatal(1, "clk_gate_ctrl: WAKE_CYCLES out of range");
  end
  if (IDLE_CYCLES < IDLE_MIN || IDLE_CYCLES > IDLE_MAX) begin : g_bad_idle
    $fatal(1, "clk_gate_ctrl: IDLE_CYCLES out of range");
  end
  if (CNT_W < CNT_W_MIN) begin : g_bad_cnt
    $fatal(1, "clk_gate_ctrl: CNT_W out of range");
  end

  state_t              state_q, state_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [CNT_W-1:0]    wake_cnt_q, wake_cnt_d;
  logic                en_q, en_d;
  logic                ack_q, ack_d;
  logic                idle_q, idle_d;

  logic act;
  logic wake;
  logic run_clr;
  logic run_inc;
  logic run_tc;

  assign act  = req | busy | force_on;
  assign wake = req | force_on;

  clk_gate_idle_timer #(
    .LIMIT (IDLE_CYCLES)
  ) u_idle_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (run_clr),
    .inc   (run_inc),
    .tc    (run_tc)
  );

  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    wake_cnt_d = wake_cnt_q;
    run_clr    = 1'b0;
    run_inc    = 1'b0;

    case (state_q)
      OFF: begin
        if (wake) begin
          state_d  = WAKE;
          settle_d = SETTLE_W'(WAKE_CYCLES - 1);
          if (wake_cnt_q != '1) begin
            wake_cnt_d = wake_cnt_q + CNT_W'(1);
          end
        end
      end
      WAKE: begin
        // Inputs are deliberately ignored here: a started wake always completes.
        if (settle_q == '0) begin
          state_d = ON;
          run_clr = 1'b1;
        end else begin
          settle_d = settle_q - SETTLE_W'(1);
        end
      end
      ON: begin
        if (act) begin
          run_clr = 1'b1;
        end else if (run_tc) begin
          state_d = OFF;
        end else begin
          run_inc = 1'b1;
        end
      end
      default: begin
        state_d = OFF;
      end
    endcase

    // Outputs are registered copies decoded from the next state, so en and
    // ack move on the same edge as the transition that causes them.
    en_d   = (state_d != OFF);
    ack_d  = (state_d == ON);
    idle_d = (state_d == OFF);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= OFF;
      settle_q   <= '0;
      wake_cnt_q <= '0;
      en_q       <= 1'b0;
      ack_q      <= 1'b0;
      idle_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      wake_cnt_q <= wake_cnt_d;
      en_q       <= en_d;
      ack_q      <= ack_d;
      idle_q     <= idle_d;
    end
  end

  assign en       = en_q;
  assign ack      = ack_q;
  assign idle     = idle_q;
  assign wake_cnt = wake_cnt_q;

endmodule
